// File: rtl/spi_pkg.sv
// Shared constants for the SPI register transaction controller.
// Command byte layout, idle MISO value and FSM state encoding.
package spi_pkg;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_RSVD_BIT = 6;

    localparam logic [7:0] IDLE_MISO_BYTE = 8'h00;

    localparam logic [0:0] S_CMD  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-file bus between the SPI controller and the PWM config regs.
// The controller is the master; the register file answers reads combinationally.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 6
);

    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_write,
        output reg_read,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_write,
        input  reg_read,
        output reg_rdata
    );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Decodes the SPI command byte and turns following data bytes into
// register writes/reads, with optional burst address auto-increment.
module spi_reg_ctrl #(
    parameter int ADDR_W   = 6,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_n,
    input  logic          byte_sync,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    output logic          txn_active,
    spi_reg_ctrl_if.master rbus
);

    import spi_pkg::*;

    logic [0:0] state;
    logic       wr_mode;
    logic       rd_pend;

    assign txn_active = (state == S_DATA);

    // Transaction FSM: command decode, direction and pending-read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CMD;
            wr_mode <= 1'b0;
            rd_pend <= 1'b0;
        end else if (cs_n) begin
            state   <= S_CMD;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            case (state)
                S_CMD: begin
                    if (byte_sync) begin
                        state   <= S_DATA;
                        wr_mode <= data_in[CMD_RW_BIT];
                        rd_pend <= ~data_in[CMD_RW_BIT];
                    end
                end
                S_DATA: begin
                    if (byte_sync && !wr_mode) begin
                        rd_pend <= 1'b1;
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end

    // Registered bus outputs: address counter, strobes and MISO byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbus.reg_addr  <= '0;
            rbus.reg_wdata <= 8'h00;
            rbus.reg_write <= 1'b0;
            rbus.reg_read  <= 1'b0;
            data_out       <= IDLE_MISO_BYTE;
        end else begin
            rbus.reg_write <= 1'b0;
            rbus.reg_read  <= 1'b0;
            // A committed write advances the address one cycle after its strobe.
            if (rbus.reg_write && AUTO_INC) begin
                rbus.reg_addr <= rbus.reg_addr + ADDR_W'(1);
            end
            if (cs_n) begin
                data_out <= IDLE_MISO_BYTE;
            end else begin
                case (state)
                    S_CMD: begin
                        data_out <= IDLE_MISO_BYTE;
                        if (byte_sync) begin
                            rbus.reg_addr <= data_in[ADDR_W-1:0];
                        end
                    end
                    S_DATA: begin
                        if (byte_sync && wr_mode) begin
                            rbus.reg_wdata <= data_in;
                            rbus.reg_write <= 1'b1;
                        end
                        if (byte_sync && !wr_mode && AUTO_INC) begin
                            rbus.reg_addr <= rbus.reg_addr + ADDR_W'(1);
                        end
                        if (rd_pend) begin
                            rbus.reg_read <= 1'b1;
                        end
                        if (rbus.reg_read) begin
                            data_out <= rbus.reg_rdata;
                        end
                    end
                    default: data_out <= IDLE_MISO_BYTE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a strobe scoreboard.
// Register file is a preloaded array answering reads combinationally.
module tb_spi_reg_ctrl;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       txn_active;

    logic [7:0] regs [64];

    wr_t        exp_wr [$];
    logic [5:0] exp_rd [$];

    int n_cmp = 0;
    int n_err = 0;

    spi_reg_ctrl_if #(.ADDR_W(6)) rbus ();

    assign rbus.reg_rdata = regs[rbus.reg_addr];

    spi_reg_ctrl #(
        .ADDR_W  (6),
        .AUTO_INC(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .byte_sync (byte_sync),
        .data_in   (data_in),
        .data_out  (data_out),
        .txn_active(txn_active),
        .rbus      (rbus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        byte_sync = 1'b1;
        data_in   = b;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    // Scoreboard: every strobe must match the oldest expected access.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rbus.reg_write) begin
                chk("wr_rd_excl", rbus.reg_read, 0);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", rbus.reg_write, 0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", rbus.reg_addr, w.a);
                    chk("wr_data", rbus.reg_wdata, w.d);
                end
            end
            if (rbus.reg_read) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", rbus.reg_read, 0);
                end else begin
                    chk("rd_addr", rbus.reg_addr, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        for (int i = 0; i < 64; i++) regs[i] = 8'(i * 3 + 1);
        regs[10] = 8'hA7;
        regs[11] = 8'h5B;
        regs[4]  = 8'h01;
        regs[5]  = 8'h02;
        regs[6]  = 8'h03;
        regs[1]  = 8'hC4;
        regs[2]  = 8'h2D;
        tick(3);

        chk("rst_data_out", data_out, 0);
        chk("rst_addr", rbus.reg_addr, 0);
        chk("rst_wdata", rbus.reg_wdata, 0);
        chk("rst_write", rbus.reg_write, 0);
        chk("rst_read", rbus.reg_read, 0);
        chk("rst_txn", txn_active, 0);
        rst_n = 1'b1;
        tick(3);

        // byte_sync with cs_n high is ignored
        xfer(8'h85);
        tick(4);
        chk("cs_hi_ignore", txn_active, 0);

        // Single write
        cs_n = 1'b0;
        tick(2);
        xfer(8'h85);
        chk("wr1_txn", txn_active, 1);
        tick(8);
        push_wr(6'd5, 8'h3C);
        xfer(8'h3C);
        chk("wr1_strobe", rbus.reg_write, 1);
        chk("wr1_addr", rbus.reg_addr, 5);
        tick(1);
        chk("wr1_width", rbus.reg_write, 0);
        chk("wr1_inc", rbus.reg_addr, 6);
        chk("wr1_miso", data_out, 0);
        tick(6);
        cs_n = 1'b1;
        tick(1);
        chk("wr1_txn_end", txn_active, 0);
        tick(4);

        // Single read with cycle-exact latency
        cs_n = 1'b0;
        tick(2);
        exp_rd.push_back(6'd10);
        xfer(8'h0A);
        chk("rd1_no_early", rbus.reg_read, 0);
        tick(1);
        chk("rd1_strobe", rbus.reg_read, 1);
        chk("rd1_addr", rbus.reg_addr, 10);
        chk("rd1_dout_early", data_out, 0);
        tick(1);
        chk("rd1_width", rbus.reg_read, 0);
        chk("rd1_dout", data_out, 8'hA7);
        tick(6);
        exp_rd.push_back(6'd11);
        xfer(8'h00);
        tick(8);
        chk("rd1_dout2", data_out, 8'h5B);
        cs_n = 1'b1;
        tick(1);
        chk("rd1_dout_idle", data_out, 0);
        chk("rd1_txn_end", txn_active, 0);
        tick(4);

        // Burst write wrapping 62, 63, 0
        cs_n = 1'b0;
        tick(2);
        xfer(8'hBE);
        tick(8);
        push_wr(6'd62, 8'h11);
        xfer(8'h11);
        tick(8);
        push_wr(6'd63, 8'h22);
        xfer(8'h22);
        tick(8);
        push_wr(6'd0, 8'h33);
        xfer(8'h33);
        tick(8);
        chk("bw_wrap_addr", rbus.reg_addr, 1);
        cs_n = 1'b1;
        tick(4);

        // Burst read 4..6, last read cancelled by cs_n rising
        cs_n = 1'b0;
        tick(2);
        exp_rd.push_back(6'd4);
        xfer(8'h04);
        tick(8);
        chk("br_miso0", data_out, 8'h01);
        exp_rd.push_back(6'd5);
        xfer(8'hFF);
        tick(8);
        chk("br_miso1", data_out, 8'h02);
        exp_rd.push_back(6'd6);
        xfer(8'h5A);
        tick(8);
        chk("br_miso2", data_out, 8'h03);
        xfer(8'h00);
        cs_n = 1'b1;
        tick(1);
        chk("br_cancel", rbus.reg_read, 0);
        tick(6);
        chk("br_dout_idle", data_out, 0);

        // Abort write before data byte, then read addr 1
        cs_n = 1'b0;
        tick(2);
        xfer(8'h83);
        tick(6);
        cs_n = 1'b1;
        tick(1);
        chk("ab_txn", txn_active, 0);
        tick(6);
        cs_n = 1'b0;
        tick(2);
        exp_rd.push_back(6'd1);
        xfer(8'h01);
        tick(8);
        chk("ab_rd_dout", data_out, 8'hC4);
        exp_rd.push_back(6'd2);
        xfer(8'h00);
        tick(8);
        chk("ab_rd_dout2", data_out, 8'h2D);
        cs_n = 1'b1;
        tick(4);

        // Async reset mid-burst write, no partial write afterwards
        cs_n = 1'b0;
        tick(2);
        xfer(8'h81);
        tick(8);
        push_wr(6'd1, 8'h55);
        xfer(8'h55);
        tick(8);
        chk("mr_pre_addr", rbus.reg_addr, 2);
        byte_sync = 1'b1;
        data_in   = 8'h66;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_data_out", data_out, 0);
        chk("mr_addr", rbus.reg_addr, 0);
        chk("mr_wdata", rbus.reg_wdata, 0);
        chk("mr_write", rbus.reg_write, 0);
        chk("mr_read", rbus.reg_read, 0);
        chk("mr_txn", txn_active, 0);
        byte_sync = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("mr_txn_after", txn_active, 0);
        chk("mr_wr_after", rbus.reg_write, 0);
        cs_n = 1'b1;
        tick(3);

        // Recovery write after reset
        cs_n = 1'b0;
        tick(2);
        xfer(8'h87);
        tick(8);
        push_wr(6'd7, 8'h9A);
        xfer(8'h9A);
        tick(8);
        cs_n = 1'b1;
        tick(4);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
